// File: rtl/cdb_arbiter_pkg.sv
// Shared Tomasulo types: ROB geometry and the common data bus entry.
// No logic; pure declarations.
// No flow control here; consumers define their own handshakes.
package tomasula_types;

  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Rotating-priority picker with its own rr_ptr register.
// Latency: grant is combinational in the request cycle; pointer moves on the edge.
// Backpressure: none; a held request simply waits for its turn.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] rr_ptr_nxt;
  logic             any_win;
  int               idx;

  // Scan upward from rr_ptr with wrap; the first active request wins.
  always_comb begin
    grant      = '0;
    rr_ptr_nxt = rr_ptr;
    any_win    = 1'b0;
    idx        = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(rr_ptr) + i) % N;
      if (!rst && !any_win && req[idx]) begin
        grant[idx] = 1'b1;
        any_win    = 1'b1;
        rr_ptr_nxt = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else begin
      rr_ptr <= rr_ptr_nxt;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: picks one FU result per cycle, squashes flushed tags, broadcasts it.
// Latency: grant same cycle, broadcast registered one cycle later; optional CDB_ARB_PERF_EN counters.
// Backpressure: requesters hold req/tag/data until grant; the bus itself is never stalled.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ROB_DEPTH = tomasula_types::ROB_DEPTH,
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
  input  logic [NUM_REQ-1:0][31:0]        req_data,
  output logic [NUM_REQ-1:0]              grant,
  input  logic                            flush_in_prog,
  input  logic [ROB_DEPTH-1:0]            invalidated_n,
  output logic                            cdb_valid,
  output logic [TAG_W-1:0]                cdb_tag,
  output logic [31:0]                     cdb_data,
  output logic [ROB_DEPTH-1:0]            set_rob_valid
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_busy_cnt,
  output logic [31:0]                     perf_conflict_cnt
`endif
);

  import tomasula_types::*;

  cdb_entry_t win_entry;
  cdb_entry_t entry_q;
  logic       any_grant;
  logic       squash_grant;
  logic       squash_live;
  logic       valid_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    win_entry = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_entry.tag  = req_tag[i];
        win_entry.data = req_data[i];
      end
    end
  end

  assign any_grant    = |grant;
  // A squashed winner still consumes its grant but never reaches the bus.
  assign squash_grant = flush_in_prog & ~invalidated_n[win_entry.tag];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (any_grant) begin
      valid_q <= ~squash_grant;
      entry_q <= win_entry;
    end else begin
      valid_q <= 1'b0;
    end
  end

  // A flush landing while the entry sits in the register kills it this cycle.
  assign squash_live   = flush_in_prog & ~invalidated_n[entry_q.tag];
  assign cdb_valid     = valid_q & ~squash_live;
  assign cdb_tag       = entry_q.tag;
  assign cdb_data      = entry_q.data;
  assign set_rob_valid = cdb_valid ? (ROB_DEPTH'(1) << entry_q.tag) : '0;

`ifdef CDB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy_cnt     <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (cdb_valid && (perf_busy_cnt != '1)) begin
        perf_busy_cnt <= perf_busy_cnt + 32'd1;
      end
      if (($countones(req) > 1) && (perf_conflict_cnt != '1)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios then randomized traffic.
// Driver predicts grant and pushes broadcast expectations; a monitor pops and compares.
module tb_cdb_arbiter;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][2:0]  req_tag;
  logic [3:0][31:0] req_data;
  logic [3:0]       grant;
  logic             flush_in_prog;
  logic [7:0]       invalidated_n;
  logic             cdb_valid;
  logic [2:0]       cdb_tag;
  logic [31:0]      cdb_data;
  logic [7:0]       set_rob_valid;
`ifdef CDB_ARB_PERF_EN
  logic [31:0]      perf_busy_cnt;
  logic [31:0]      perf_conflict_cnt;
  logic [31:0]      m_busy;
  logic [31:0]      m_conflict;
`endif

  cdb_arbiter #(.NUM_REQ(4), .ROB_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_tag       (req_tag),
    .req_data      (req_data),
    .grant         (grant),
    .flush_in_prog (flush_in_prog),
    .invalidated_n (invalidated_n),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .cdb_data      (cdb_data),
    .set_rob_valid (set_rob_valid)
`ifdef CDB_ARB_PERF_EN
    ,
    .perf_busy_cnt     (perf_busy_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [2:0]  tag;
    logic [31:0] dat;
    logic        known;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;

  // Requester-side state and the reference model of the arbiter.
  logic        p_req[4];
  logic [2:0]  p_tag[4];
  logic [31:0] p_dat[4];
  int          m_ptr;
  logic [2:0]  m_tag;
  logic [31:0] m_dat;
  logic        m_known;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] t, input logic [31:0] d);
    p_req[i] = 1'b1;
    p_tag[i] = t;
    p_dat[i] = d;
  endtask

  task automatic fill_all();
    for (int i = 0; i < 4; i++)
      if (!p_req[i]) set_req(i, 3'($urandom_range(7, 0)), $urandom);
  endtask

  task automatic drive_cycle(input logic r, input logic fl, input logic [7:0] iv);
    int         w;
    logic [3:0] eg;
    logic       sq;
    exp_t       e;
    @(negedge clk);
    rst           = r;
    flush_in_prog = fl;
    invalidated_n = iv;
    for (int i = 0; i < 4; i++) begin
      req[i]      = p_req[i];
      req_tag[i]  = p_tag[i];
      req_data[i] = p_dat[i];
    end
    #2;
    w  = -1;
    eg = '0;
    if (!r) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (w < 0 && p_req[idx]) w = idx;
      end
    end
    if (w >= 0) eg[w] = 1'b1;
    check("grant", {28'd0, grant}, {28'd0, eg});
    if (r) begin
      m_ptr = 0; m_tag = '0; m_dat = '0; m_known = 1'b1;
      e = '{1'b0, 3'd0, 32'd0, 1'b1};
    end else if (w >= 0) begin
      sq      = fl && !iv[p_tag[w]];
      m_tag   = p_tag[w];
      m_dat   = p_dat[w];
      m_known = !sq;
      e       = '{!sq, m_tag, m_dat, m_known};
      m_ptr   = (w + 1) % 4;
      p_req[w] = 1'b0;
    end else begin
      e = '{1'b0, m_tag, m_dat, m_known};
    end
    q.push_back(e);
  endtask

  // Monitor: pops the entry loaded at each edge, compares the broadcast late in the cycle.
  initial begin
    exp_t       cur;
    logic       ev;
    logic [7:0] one;
    one = 8'd1;
    cur = '{1'b0, 3'd0, 32'd0, 1'b0};
`ifdef CDB_ARB_PERF_EN
    m_busy = '0;
    m_conflict = '0;
`endif
    wait (q.size() > 0);
    forever begin
      @(posedge clk);
      #1;
`ifdef CDB_ARB_PERF_EN
      check("perf_busy_cnt", perf_busy_cnt, m_busy);
      check("perf_conflict_cnt", perf_conflict_cnt, m_conflict);
`endif
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: queue empty at t=%0t, required an expected entry", $time);
      end else begin
        cur = q.pop_front();
      end
      @(negedge clk);
      #3;
      ev = cur.v && !(flush_in_prog && !invalidated_n[cur.tag]);
      check("cdb_valid", {31'd0, cdb_valid}, {31'd0, ev});
      if (cur.known) begin
        check("cdb_tag", {29'd0, cdb_tag}, {29'd0, cur.tag});
        check("cdb_data", cdb_data, cur.dat);
      end
      check("set_rob_valid", {24'd0, set_rob_valid}, {24'd0, (ev ? (one << cur.tag) : 8'd0)});
`ifdef CDB_ARB_PERF_EN
      if (rst) begin
        m_busy = '0;
        m_conflict = '0;
      end else begin
        if (ev && m_busy != 32'hFFFF_FFFF) m_busy = m_busy + 1;
        if ($countones(req) > 1 && m_conflict != 32'hFFFF_FFFF) m_conflict = m_conflict + 1;
      end
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; flush_in_prog = 1'b0; invalidated_n = 8'hFF;
    req = '0; req_tag = '0; req_data = '0;
    for (int i = 0; i < 4; i++) begin
      p_req[i] = 1'b0; p_tag[i] = '0; p_dat[i] = '0;
    end
    m_ptr = 0; m_tag = '0; m_dat = '0; m_known = 1'b1;

    repeat (2) drive_cycle(1'b1, 1'b0, 8'hFF);

    // Single request on requester 1.
    set_req(1, 3'd5, 32'hDEADBEEF);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b0, 8'hFF);

    // Saturating round robin from a freshly reset pointer, then drain.
    drive_cycle(1'b1, 1'b0, 8'hFF);
    repeat (8) begin
      fill_all();
      drive_cycle(1'b0, 1'b0, 8'hFF);
    end
    repeat (4) drive_cycle(1'b0, 1'b0, 8'hFF);

    // Rotation after a win: requester 2 wins, then 0101 goes to requester 0.
    set_req(2, 3'd1, 32'h2222_0001);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    set_req(0, 3'd2, 32'h0000_0A0A);
    set_req(2, 3'd4, 32'h2222_0002);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b0, 8'hFF);

    // Squash on grant, then 0011 must pick requester 1.
    set_req(0, 3'd3, 32'h3333_3333);
    drive_cycle(1'b0, 1'b1, 8'b1111_0111);
    set_req(0, 3'd0, 32'h0000_1111);
    set_req(1, 3'd7, 32'h7777_7777);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b0, 8'hFF);

    // Squash in flight on tag 6.
    set_req(3, 3'd6, 32'h6666_6666);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b1, 8'b1011_1111);
    drive_cycle(1'b0, 1'b0, 8'hFF);

    // Reset one cycle after a grant with all requesters busy.
    fill_all();
    drive_cycle(1'b0, 1'b0, 8'hFF);
    fill_all();
    drive_cycle(1'b1, 1'b0, 8'hFF);
    drive_cycle(1'b0, 1'b0, 8'hFF);
    repeat (4) drive_cycle(1'b0, 1'b0, 8'hFF);

    // Randomized traffic with flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if (!p_req[i] && $urandom_range(1, 0) == 1)
          set_req(i, 3'($urandom_range(7, 0)), $urandom);
      drive_cycle($urandom_range(63, 0) == 0, $urandom_range(3, 0) == 0,
                  8'($urandom | $urandom));
    end

    @(negedge clk);
    #4;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
